// File: rtl/vga_timing_if.sv
// VGA raster timing bundle.
// Carries the pixel enable, the current raster coordinates and the decoded sync,
// blanking and frame-start strobes from the timing generator to its consumers.
//   pixel_clk   - 25 MHz pixel enable / DAC pixel clock
//   DrawX       - horizontal count, 0..H_TOTAL-1
//   DrawY       - vertical count, 0..V_TOTAL-1
//   hs, vs      - active-low syncs (vs doubles as the sprite-motion frame clock)
//   blank_n     - high inside the visible area
//   frame_start - one-Clk pulse when the raster returns to (0, 0)
interface vga_timing_if;
    logic       pixel_clk;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic       frame_start;

    modport master (
        output pixel_clk,
        output DrawX,
        output DrawY,
        output hs,
        output vs,
        output blank_n,
        output frame_start
    );

    modport slave (
        input pixel_clk,
        input DrawX,
        input DrawY,
        input hs,
        input vs,
        input blank_n,
        input frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480 @ 60 Hz from a 50 MHz clock by default).
// A pixel enable toggles every Clk; the horizontal/vertical counters advance on
// the edges where the enable is already high, so each pixel lasts two Clk cycles.
// Ports:
//   Clk   - 50 MHz system clock
//   Reset - synchronous, active-low reset
//   vga   - timing outputs (see vga_timing_if)
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic          Clk,
    input  logic          Reset,
    vga_timing_if.master  vga
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       pclk_q, pclk_d;
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_n_q, blank_n_d;
    logic       fs_q, fs_d;

    always_comb begin
        pclk_d = ~pclk_q;
        hc_d   = hc_q;
        vc_d   = vc_q;
        fs_d   = 1'b0;

        if (pclk_q) begin
            if (hc_q == H_LAST) begin
                hc_d = 10'd0;
                if (vc_q == V_LAST) begin
                    vc_d = 10'd0;
                    fs_d = 1'b1;
                end else begin
                    vc_d = vc_q + 10'd1;
                end
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end

        // Decode from the next counts so the registered strobes line up with DrawX/DrawY.
        hs_d      = ~((hc_d >= HS_START) && (hc_d < HS_END));
        vs_d      = ~((vc_d >= VS_START) && (vc_d < VS_END));
        blank_n_d = (hc_d < H_VIS_END) && (vc_d < V_VIS_END);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pclk_q    <= 1'b0;
            hc_q      <= 10'd0;
            vc_q      <= 10'd0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            pclk_q    <= pclk_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            fs_q      <= fs_d;
        end
    end

    assign vga.pixel_clk   = pclk_q;
    assign vga.DrawX       = hc_q;
    assign vga.DrawY       = vc_q;
    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
    assign vga.blank_n     = blank_n_q;
    assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level timing and a
// shrunken instance (16x12 raster) for frame-level timing, resets and random
// reset stimulus. Outputs are checked every cycle against a time-based model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pclk;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_full = 1'b0;
    logic rst_small = 1'b0;
    bit   chk_en = 1'b0;
    int   t_full = 0;
    int   t_small = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    vga_timing_if if_full ();
    vga_timing_if if_small ();

    vga_timing_gen u_full (
        .Clk   (clk),
        .Reset (rst_full),
        .vga   (if_full)
    );

    vga_timing_gen #(
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (3),
        .V_VISIBLE (6),
        .V_FRONT   (2),
        .V_SYNC    (2),
        .V_BACK    (2)
    ) u_small (
        .Clk   (clk),
        .Reset (rst_small),
        .vga   (if_small)
    );

    // Edges seen with Reset high since the last reset edge.
    always @(posedge clk) begin
        t_full  <= rst_full  ? t_full + 1  : 0;
        t_small <= rst_small ? t_small + 1 : 0;
    end

    // Expected outputs t edges after release: each pixel occupies two edges.
    function automatic exp_t model(int ht, int vt, int hv, int hf, int hsw,
                                   int vv, int vf, int vsw, int t);
        exp_t e;
        int n, hc, vc;
        n    = t / 2;
        hc   = n % ht;
        vc   = (n / ht) % vt;
        e.pclk = (t % 2) == 1;
        e.x  = 10'(hc);
        e.y  = 10'(vc);
        e.hs = !(hc >= hv + hf && hc < hv + hf + hsw);
        e.vs = !(vc >= vv + vf && vc < vv + vf + vsw);
        e.bl = (hc < hv) && (vc < vv);
        e.fs = (t > 0) && (t % 2 == 0) && (n % (ht * vt) == 0);
        return e;
    endfunction

    task automatic cmp_frame(string name, exp_t act, exp_t exp, int t);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0d act pclk=%0b x=%0d y=%0d hs=%0b vs=%0b bl=%0b fs=%0b exp pclk=%0b x=%0d y=%0d hs=%0b vs=%0b bl=%0b fs=%0b",
                      name, t, act.pclk, act.x, act.y, act.hs, act.vs, act.bl, act.fs,
                      exp.pclk, exp.x, exp.y, exp.hs, exp.vs, exp.bl, exp.fs);
    endtask

    task automatic check_val(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_frame("full", {if_full.pixel_clk, if_full.DrawX, if_full.DrawY, if_full.hs,
                               if_full.vs, if_full.blank_n, if_full.frame_start},
                      model(800, 525, 640, 16, 96, 480, 10, 2, t_full), t_full);
            cmp_frame("small", {if_small.pixel_clk, if_small.DrawX, if_small.DrawY, if_small.hs,
                                if_small.vs, if_small.blank_n, if_small.frame_start},
                      model(16, 12, 8, 2, 3, 6, 2, 2, t_small), t_small);
        end
    end

    initial begin
        int  hs_low;
        int  bl_hi;
        int  vs_low;
        int  fs_cnt;
        bit  found;

        @(posedge clk);
        chk_en = 1'b1;
        repeat (5) @(negedge clk);
        check_val("reset_pclk", int'(if_full.pixel_clk), 0);
        check_val("reset_x", int'(if_full.DrawX), 0);
        check_val("reset_syncs", int'({if_full.hs, if_full.vs, if_full.blank_n}), 7);
        check_val("reset_fs", int'(if_full.frame_start), 0);

        rst_full  = 1'b1;
        rst_small = 1'b1;
        hs_low = 0;
        bl_hi  = 0;
        vs_low = 0;
        fs_cnt = 0;
        for (int e = 1; e <= 3300; e++) begin
            @(negedge clk);
            if (e <= 1600 && !if_full.hs) hs_low++;
            if (e >= 384 && e < 768) begin
                if (if_small.blank_n) bl_hi++;
                if (!if_small.vs) vs_low++;
                if (if_small.frame_start) fs_cnt++;
            end
            case (e)
                1:    check_val("rel_pclk_e1", int'(if_full.pixel_clk), 1);
                2:    check_val("rel_x_e2", int'(if_full.DrawX), 1);
                4:    check_val("rel_x_e4", int'(if_full.DrawX), 2);
                1279: check_val("blank_e1279", int'(if_full.blank_n), 1);
                1280: check_val("blank_fall_x640", int'({if_full.blank_n, if_full.DrawX}), 640);
                1311: check_val("hs_e1311", int'(if_full.hs), 1);
                1312: check_val("hs_fall_x656", int'({if_full.hs, if_full.DrawX}), 656);
                1503: check_val("hs_e1503", int'(if_full.hs), 0);
                1504: check_val("hs_rise_x752", int'({if_full.hs, if_full.DrawX}), 1024 + 752);
                1599: check_val("wrap_pre", int'({if_full.DrawX, if_full.DrawY}), 799 * 1024);
                1600: check_val("wrap_post", int'({if_full.DrawX, if_full.DrawY}), 1);
                256:  check_val("s_vs_fall", int'({if_small.vs, if_small.DrawY, if_small.DrawX}), 8 * 1024);
                255:  check_val("s_vs_pre", int'(if_small.vs), 1);
                383:  check_val("s_fs_pre", int'(if_small.frame_start), 0);
                384:  check_val("s_fs_first", int'({if_small.frame_start, if_small.DrawX, if_small.DrawY}),
                                1 << 20);
                385:  check_val("s_fs_post", int'(if_small.frame_start), 0);
                768:  check_val("s_fs_second", int'(if_small.frame_start), 1);
                3200: check_val("full_line2", int'({if_full.DrawX, if_full.DrawY}), 2);
                default: ;
            endcase
        end
        check_val("hs_low_per_line", hs_low, 192);
        check_val("s_blank_hi_frame", bl_hi, 96);
        check_val("s_vs_low_frame", vs_low, 64);
        check_val("s_fs_per_frame", fs_cnt, 1);

        // Mid-frame reset on the small raster.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (if_small.DrawX == 10'd5 && if_small.DrawY == 10'd3) found = 1'b1;
        end
        check_val("mid_found", int'(found), 1);
        rst_small = 1'b0;
        @(negedge clk);
        rst_small = 1'b1;
        check_val("mid_xy", int'({if_small.DrawX, if_small.DrawY}), 0);
        check_val("mid_flags", int'({if_small.pixel_clk, if_small.hs, if_small.vs, if_small.blank_n}), 7);
        @(negedge clk);
        check_val("mid_pclk_e1", int'(if_small.pixel_clk), 1);
        @(negedge clk);
        check_val("mid_x_e2", int'(if_small.DrawX), 1);

        // Reset on the edge that would wrap the frame.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (if_small.DrawX == 10'd15 && if_small.DrawY == 10'd11 && if_small.pixel_clk)
                found = 1'b1;
        end
        check_val("wrap_found", int'(found), 1);
        rst_small = 1'b0;
        @(negedge clk);
        rst_small = 1'b1;
        check_val("wrap_rst_fs", int'(if_small.frame_start), 0);
        check_val("wrap_rst_xy", int'({if_small.DrawX, if_small.DrawY}), 0);

        // Random reset pulses; the per-cycle model checks everything in between.
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(1, 600)) @(negedge clk);
            rst_small = 1'b0;
            if ($urandom_range(0, 1) == 1) rst_full = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_small = 1'b1;
            rst_full  = 1'b1;
        end
        repeat (50) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
